// File: rtl/wb_serial.sv
// Wishbone classic 8N1 serial port: TX holding register plus shifter, RX shifter
// feeding a small FIFO, two-word DATA/STATUS register map.
`timescale 1ns/1ps
module wb_serial #(
    parameter int CLKDIV = 16,
    parameter int RXLOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        txd,
    input  logic        rxd
);
    localparam int CW    = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam int DEPTH = 1 << RXLOG2;
    localparam int NW    = RXLOG2 + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} ser_state_t;

    ser_state_t tx_state_r, tx_state_n, rx_state_r, rx_state_n;
    logic [CW-1:0] tx_cnt_r, tx_cnt_n, rx_cnt_r, rx_cnt_n;
    logic [2:0]    tx_bit_r, tx_bit_n, rx_bit_r, rx_bit_n;
    logic [7:0]    tx_shift_r, tx_shift_n, rx_shift_r, rx_shift_n;
    logic [7:0]    hold_r;
    logic          hold_full_r, tx_take_s, tx_level_s;
    logic          rx_meta_r, rx_sync_r, rx_prev_r, rx_push_s, rx_ferr_set_s;
    logic [7:0]    rx_mem_r [DEPTH];
    logic [RXLOG2-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [NW-1:0] rx_count_r;
    logic          rx_empty_s, rx_full_s, push_ok_s, pop_s;
    logic          tx_ovr_r, rx_ovr_r, rx_ferr_r;
    logic          req_s, data_wr_s, stat_wr_s;
    logic [31:0]   status_s, rd_data_s;
    logic          unused_s;

    assign unused_s   = ^{sel_i, adr_i[31:1], dat_i[31:8]};
    assign req_s      = stb_i & cyc_i & ~ack_o;
    assign data_wr_s  = req_s & we_i & ~adr_i[0];
    assign stat_wr_s  = req_s & we_i & adr_i[0];
    assign rx_empty_s = (rx_count_r == {NW{1'b0}});
    assign rx_full_s  = (rx_count_r == FIFO_FULL);
    assign pop_s      = req_s & ~we_i & ~adr_i[0] & ~rx_empty_s;
    // A pop on the same edge frees the slot the push needs.
    assign push_ok_s  = rx_push_s & (~rx_full_s | pop_s);
    assign status_s   = {26'd0, rx_ferr_r, tx_ovr_r, rx_ovr_r, ~rx_empty_s,
                         (tx_state_r != S_IDLE), ~hold_full_r};

    // Read data selection for the current request
    always_comb begin
        rd_data_s = 32'hFFFF_FFFF;
        if (adr_i[0]) begin
            rd_data_s = status_s;
        end else if (rx_empty_s) begin
            rd_data_s = 32'hFFFF_FFFF;
        end else begin
            rd_data_s = {24'd0, rx_mem_r[rx_rd_ptr_r]};
        end
    end

    // Single-cycle acknowledge and registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_o <= 1'b0;
            dat_o <= 32'd0;
        end else begin
            ack_o <= req_s;
            dat_o <= (req_s & ~we_i) ? rd_data_s : 32'd0;
        end
    end

    // TX next-state logic
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bit_n   = tx_bit_r;
        tx_shift_n = tx_shift_r;
        tx_take_s  = 1'b0;
        case (tx_state_r)
            S_IDLE: begin
                if (hold_full_r) begin
                    tx_take_s  = 1'b1;
                    tx_shift_n = hold_r;
                    tx_cnt_n   = {CW{1'b0}};
                    tx_state_n = S_START;
                end else begin
                    tx_state_n = S_IDLE;
                end
            end
            S_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n   = {CW{1'b0}};
                    tx_bit_n   = 3'd0;
                    tx_state_n = S_DATA;
                end else begin
                    tx_cnt_n = tx_cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n   = {CW{1'b0}};
                    tx_shift_n = {1'b1, tx_shift_r[7:1]};
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = S_STOP;
                    end else begin
                        tx_bit_n = tx_bit_r + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r + CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n = {CW{1'b0}};
                    // Chain straight into the next frame when a byte is waiting.
                    if (hold_full_r) begin
                        tx_take_s  = 1'b1;
                        tx_shift_n = hold_r;
                        tx_state_n = S_START;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r + CNT_ONE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // TX line level for the current state
    always_comb begin
        case (tx_state_r)
            S_START: tx_level_s = 1'b0;
            S_DATA:  tx_level_s = tx_shift_r[0];
            default: tx_level_s = 1'b1;
        endcase
    end

    // TX state registers and registered txd
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= S_IDLE;
            tx_cnt_r   <= {CW{1'b0}};
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'hFF;
            txd        <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shift_r <= tx_shift_n;
            txd        <= tx_level_s;
        end
    end

    // TX holding register; a write is accepted on the edge the shifter empties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
        end else if (data_wr_s & (~hold_full_r | tx_take_s)) begin
            hold_r      <= dat_i[7:0];
            hold_full_r <= 1'b1;
        end else if (tx_take_s) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // rxd synchronizer and edge history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next-state logic
    always_comb begin
        rx_state_n    = rx_state_r;
        rx_cnt_n      = rx_cnt_r;
        rx_bit_n      = rx_bit_r;
        rx_shift_n    = rx_shift_r;
        rx_push_s     = 1'b0;
        rx_ferr_set_s = 1'b0;
        case (rx_state_r)
            S_IDLE: begin
                if (rx_prev_r & ~rx_sync_r) begin
                    rx_cnt_n   = {CW{1'b0}};
                    rx_state_n = S_START;
                end else begin
                    rx_state_n = S_IDLE;
                end
            end
            S_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_n = {CW{1'b0}};
                    rx_bit_n = 3'd0;
                    rx_state_n = rx_sync_r ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_n   = {CW{1'b0}};
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = S_STOP;
                    end else begin
                        rx_bit_n = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r + CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_n      = {CW{1'b0}};
                    rx_state_n    = S_IDLE;
                    rx_push_s     = rx_sync_r;
                    rx_ferr_set_s = ~rx_sync_r;
                end else begin
                    rx_cnt_n = rx_cnt_r + CNT_ONE;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // RX state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= S_IDLE;
            rx_cnt_r   <= {CW{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
        end
    end

    // RX FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_r[i] <= 8'd0;
            end
            rx_wr_ptr_r <= {RXLOG2{1'b0}};
            rx_rd_ptr_r <= {RXLOG2{1'b0}};
            rx_count_r  <= {NW{1'b0}};
        end else begin
            if (push_ok_s) begin
                rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
                rx_wr_ptr_r <= rx_wr_ptr_r + {{(RXLOG2-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + {{(RXLOG2-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_s})
                2'b10:   rx_count_r <= rx_count_r + {{(NW-1){1'b0}}, 1'b1};
                2'b01:   rx_count_r <= rx_count_r - {{(NW-1){1'b0}}, 1'b1};
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Sticky error flags; a set on the same edge beats the write-one-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ovr_r  <= 1'b0;
            tx_ovr_r  <= 1'b0;
            rx_ferr_r <= 1'b0;
        end else begin
            rx_ovr_r  <= (rx_push_s & rx_full_s & ~pop_s) | (rx_ovr_r & ~(stat_wr_s & dat_i[3]));
            tx_ovr_r  <= (data_wr_s & hold_full_r & ~tx_take_s) | (tx_ovr_r & ~(stat_wr_s & dat_i[4]));
            rx_ferr_r <= rx_ferr_set_s | (rx_ferr_r & ~(stat_wr_s & dat_i[5]));
        end
    end
endmodule

// File: tb/tb_wb_serial.sv
// Directed bench for wb_serial: bus register table plus hand sequences for
// TX bit timing, back-to-back frames, loopback, RX errors and bus handshake.
`timescale 1ns/1ps
module tb_wb_serial;
    localparam int CLKDIV = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr_i, dat_i, dat_o;
    logic        we_i, stb_i, cyc_i, ack_o, txd, rxd;
    logic [3:0]  sel_i;
    logic        rx_drv, loop_en;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        we;
        logic        adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t vec [23];

    assign rxd = loop_en ? txd : rx_drv;

    wb_serial #(.CLKDIV(CLKDIV), .RXLOG2(2)) dut (
        .clk(clk), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic adr, input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk);
        stb_i = 1'b1; cyc_i = 1'b1; we_i = we; adr_i = {31'd0, adr}; dat_i = wd;
        @(negedge clk);
        chk("bus_ack", {31'd0, ack_o}, 32'd1);
        rd = dat_o;
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic run_vec(input int lo, input int hi);
        logic [31:0] rd;
        for (int i = lo; i <= hi; i++) begin
            bus(vec[i].we, vec[i].adr, vec[i].wd, rd);
            if (!vec[i].we) chk($sformatf("vec%0d", i), rd, vec[i].exp);
        end
    endtask

    // Called at the negedge where the start bit is first seen; samples 160 clocks.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic e;
        int   bad;
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            bad = 0;
            for (int s = 0; s < CLKDIV; s++) begin
                if (k > 0 || s > 0) @(negedge clk);
                if (txd !== e) bad++;
            end
            chk($sformatf("%s_bit%0d", tag, k), bad, 0);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (CLKDIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CLKDIV) @(negedge clk);
        end
        rx_drv = stop;
        repeat (CLKDIV) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        int bad;
        vec[0]  = '{1'b0, 1'b1, 32'h0,  32'h11};
        vec[1]  = '{1'b1, 1'b1, 32'h10, 32'h0};
        vec[2]  = '{1'b0, 1'b1, 32'h0,  32'h01};
        vec[3]  = '{1'b0, 1'b1, 32'h0,  32'h05};
        vec[4]  = '{1'b0, 1'b0, 32'h0,  32'h00};
        vec[5]  = '{1'b0, 1'b0, 32'h0,  32'hFF};
        vec[6]  = '{1'b0, 1'b0, 32'h0,  32'h81};
        vec[7]  = '{1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF};
        vec[8]  = '{1'b0, 1'b1, 32'h0,  32'h01};
        vec[9]  = '{1'b0, 1'b1, 32'h0,  32'h0D};
        vec[10] = '{1'b0, 1'b0, 32'h0,  32'h11};
        vec[11] = '{1'b0, 1'b0, 32'h0,  32'h22};
        vec[12] = '{1'b0, 1'b0, 32'h0,  32'h33};
        vec[13] = '{1'b0, 1'b0, 32'h0,  32'h44};
        vec[14] = '{1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF};
        vec[15] = '{1'b1, 1'b1, 32'h08, 32'h0};
        vec[16] = '{1'b0, 1'b1, 32'h0,  32'h01};
        vec[17] = '{1'b0, 1'b1, 32'h0,  32'h21};
        vec[18] = '{1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF};
        vec[19] = '{1'b1, 1'b1, 32'h20, 32'h0};
        vec[20] = '{1'b0, 1'b1, 32'h0,  32'h01};
        vec[21] = '{1'b0, 1'b1, 32'h0,  32'h01};
        vec[22] = '{1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF};

        reset = 1'b0; adr_i = 32'd0; dat_i = 32'd0; we_i = 1'b0; sel_i = 4'hF;
        stb_i = 1'b0; cyc_i = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
        #12;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("status_after_reset", rd, 32'h01);

        // Single byte: start bit appears 2 clocks after the ack edge.
        bus(1'b1, 1'b0, 32'h55, rd);
        n = 0;
        while (txd !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_latency", n, 2);
        check_frame(8'h55, "tx55");
        @(negedge clk);
        chk("tx_idle_after", {31'd0, txd}, 32'd1);

        // Back-to-back writes: two frames with no gap, third write overruns.
        repeat (5) @(negedge clk);
        fork
            begin
                bus(1'b1, 1'b0, 32'hA5, rd);
                bus(1'b1, 1'b0, 32'h3C, rd);
                bus(1'b1, 1'b0, 32'h99, rd);
            end
            begin
                n = 0;
                while (txd !== 1'b0 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_start", {31'd0, txd}, 32'd0);
                check_frame(8'hA5, "b2b_a5");
                @(negedge clk);
                check_frame(8'h3C, "b2b_3c");
                bad = 0;
                repeat (32) begin
                    @(negedge clk);
                    if (txd !== 1'b1) bad++;
                end
                chk("b2b_third_dropped", bad, 0);
            end
        join
        run_vec(0, 2);

        // Reset in the middle of a frame of zeros.
        bus(1'b1, 1'b0, 32'h00, rd);
        repeat (60) @(negedge clk);
        chk("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_txd", {31'd0, txd}, 32'd1);
        chk("midrst_ack", {31'd0, ack_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("status_after_midrst", rd, 32'h01);

        // Loopback of three bytes, then drain the FIFO.
        loop_en = 1'b1;
        bus(1'b1, 1'b0, 32'h00, rd);
        repeat (200) @(negedge clk);
        bus(1'b1, 1'b0, 32'hFF, rd);
        repeat (200) @(negedge clk);
        bus(1'b1, 1'b0, 32'h81, rd);
        repeat (200) @(negedge clk);
        loop_en = 1'b0;
        run_vec(3, 8);

        // Five frames into a four-deep FIFO.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        run_vec(9, 16);

        // Framing error: stop bit low.
        send_rx(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        run_vec(17, 20);

        // Three-clock glitch is rejected at the start-bit sample.
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        run_vec(21, 22);

        // Request held for four cycles: ack on alternate cycles only.
        @(negedge clk);
        stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold_ack%0d", k), {31'd0, ack_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("hold_dat%0d", k), dat_o, (k % 2 == 0) ? 32'h01 : 32'h00);
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        @(negedge clk);
        chk("hold_ack_end", {31'd0, ack_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_serial.md
# wb_serial

Hardware Wishbone serial port (8N1 UART) that answers core data-bus cycles routed to the serial window (word addresses 0x20–0x21). It is a Wishbone classic responder driven by the bus mux: the core writes bytes for transmission on `txd`, and reads bytes received on `rxd` from a small FIFO. It replaces the simulation-only serial device, keeps the same two-word register map, and runs entirely in the core clock domain.

## Interface
- `CLKDIV`, 16: core clocks per serial bit; must be ≥ 4.
- `RXLOG2`, 2: log2 of the RX FIFO depth (default depth 4).

- `clk` in 1: core clock.
- `reset` in 1: reset, asynchronous, active-low.
- `adr_i` in 32: word address; only `adr_i[0]` is decoded; the mux has already matched the base.
- `dat_i` in 32: write data; only `[7:0]` is used for DATA, `[5:3]` for STATUS.
- `dat_o` out 32: read data, valid while `ack_o`=1.
- `we_i` in 1: 1 = write.
- `sel_i` in 4: ignored; every access is a full word.
- `stb_i`, `cyc_i` in 1: request; active only when both are 1.
- `ack_o` out 1: single-cycle acknowledge.
- `txd` out 1: serial output, idle high.
- `rxd` in 1: serial input, asynchronous to `clk`.

## Operation
- Register map:
  - `adr_i[0]`=0, DATA.
    - Write: loads `dat_i[7:0]` into the TX holding register if it is empty. If it is full, the write is dropped and `tx_ovr` is set.
    - Read: pops the RX FIFO head and returns `{24'h0, byte}`. When the FIFO is empty it returns 32'hFFFFFFFF and nothing is popped.
  - `adr_i[0]`=1, STATUS (read):
    - bit0 `tx_ready`: holding register empty.
    - bit1 `tx_busy`: TX FSM not IDLE.
    - bit2 `rx_avail`: FIFO non-empty.
    - bit3 `rx_ovr`, bit4 `tx_ovr`, bit5 `rx_ferr`: sticky flags.
    - All other bits read 0.
  - STATUS write: writing 1 to bit3/4/5 clears that flag; writing 0 leaves it unchanged.
- Bus request handling:
  - A request is accepted when `stb_i & cyc_i & ~ack_o`.
  - `ack_o` rises on the next edge, lasts exactly one cycle, and then drops even if `stb_i` stays high.
  - Side effects (pop, load, clear) occur on the same edge `ack_o` rises.
- TX FSM (IDLE → START → DATA → STOP):
  - Each bit lasts `CLKDIV` clocks; 8 data bits, LSB first.
  - In IDLE with the holding register full: move the byte to the shifter, empty the holding register, go to START.
  - At the end of STOP: if the holding register is full, go directly to START (no idle gap); otherwise go to IDLE.
  - `txd` levels: START 0, DATA = bit, STOP and IDLE 1.
- RX input and FSM:
  - `rxd` passes through a 2-flop synchronizer.
  - IDLE: a synchronized falling edge enters START.
  - START: sample at `CLKDIV/2`. If the sample is high (glitch), return to IDLE.
  - DATA: sample every `CLKDIV` clocks at mid-bit; 8 bits, LSB first.
  - STOP: sample at mid-bit, then return to IDLE immediately.
    - Sample high: push the byte into the FIFO; if the FIFO is full, drop the byte and set `rx_ovr`.
    - Sample low: discard the byte and set `rx_ferr`.
- Simultaneous events:
  - Pop and push on the same edge with a full FIFO: the pop takes effect first, the push succeeds, and `rx_ovr` is not set.
  - DATA write on the same edge the shifter takes the holding byte: the write is accepted.
  - Flag set and W1C on the same edge: the set wins.

## Timing
- Reset values: `ack_o`=0, `dat_o`=0, `txd`=1.
- State after reset: both FSMs IDLE, FIFO empty, holding register empty, all flags 0.
- Reset asserted mid-frame aborts the frame immediately and forces `txd` high asynchronously.
- Bus latency: 1 cycle from accepted request to `ack_o`. Maximum throughput is one access per 2 cycles.
- TX timing:
  - `txd` falls 2 clocks after the DATA-write `ack_o` edge when TX was IDLE.
  - One frame is 10×`CLKDIV` clocks; back-to-back frames have no gap.
- RX timing:
  - Capture latency is 2 (synchronizer) + 9.5×`CLKDIV` clocks from the start edge.
  - `rx_avail` becomes visible 1 clock after the push.
- `dat_o` returns to 0 when `ack_o` is low.

## Test plan
- Reset: drive `reset`=0 mid-TX-frame → `txd`=1 and `ack_o`=0 immediately; STATUS reads 0x01 after release.
- TX single byte: with `CLKDIV`=16, write DATA=0x55 → `txd` is 0 for 16 clocks, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then 1; total 160 clocks.
- TX back-to-back and overrun:
  - Write 0xA5, 0x3C, 0x99 in quick succession → the first two go out with no gap; the third is dropped and STATUS bit4=1.
  - Writing STATUS with 0x10 then clears bit4.
- RX loopback (`rxd`=`txd`):
  - Send 0x00, 0xFF, 0x81 → DATA reads return 0x00000000, 0x000000FF, 0x00000081.
  - A fourth read returns 0xFFFFFFFF.
- RX overflow and framing errors:
  - Inject 5 frames with FIFO depth 4 → `rx_ovr`=1, the first 4 bytes are kept, the fifth is lost.
  - Inject a frame with stop bit 0 → `rx_ferr`=1 and no push.
- RX glitch and bus protocol:
  - A 3-clock low pulse on `rxd` produces no push and no flags.
  - Holding `stb_i`/`cyc_i` high for 4 cycles produces `ack_o` pulses on cycles 2 and 4 only.
